// File: rtl/snake_pkg.sv
// snake_pkg: direction codes, move width and the opposite-direction helper shared by player inputs
package snake_pkg;
  localparam int MOVE_W = 32;
  typedef logic [2:0] dir_t;
  localparam dir_t DIR_UP    = 3'd1;
  localparam dir_t DIR_RIGHT = 3'd2;
  localparam dir_t DIR_DOWN  = 3'd3;
  localparam dir_t DIR_LEFT  = 3'd4;
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a == DIR_UP && b == DIR_DOWN) || (a == DIR_DOWN && b == DIR_UP) ||
           (a == DIR_RIGHT && b == DIR_LEFT) || (a == DIR_LEFT && b == DIR_RIGHT);
  endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchroniser, stable-count debounce and press-edge pulse for one active-low button
// ports: clock, reset (async, active-high), btn_n (raw, active-low) -> pressed (debounced level), press_pulse (one cycle, on the flip edge)
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse
);
  logic [1:0] sync;
  logic level;
  logic expire;
  logic [CNT_W-1:0] cnt;
  assign level = ~sync[1];
  // the flip happens on the edge where the counter has already seen DEBOUNCE_CYCLES-1 mismatches and one more is present
  assign expire = (level != pressed) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press_pulse = expire && level;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= 2'b11;
      pressed <= 1'b0;
      cnt <= '0;
    end else begin
      sync <= {sync[0], btn_n};
      cnt <= (level == pressed || expire) ? '0 : cnt + CNT_W'(1);
      if (expire) pressed <= level;
    end
  end
endmodule

// File: rtl/snake_dir_input.sv
// snake_dir_input: debounced buttons -> validated 2-deep turn queue -> committed 32-bit move code
// ports: clock, reset (async, active-high), up_n/right_n/down_n/left_n (raw, active-low), step (game step pulse)
//        move (committed code 1..4), pending (queued turns 0..2), turn_dropped (pulse when a valid turn hit a full queue)
module snake_dir_input
  import snake_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20,
  parameter int INIT_MOVE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic up_n,
  input  logic right_n,
  input  logic down_n,
  input  logic left_n,
  input  logic step,
  output logic [MOVE_W-1:0] move,
  output logic [1:0] pending,
  output logic turn_dropped
);
  logic [3:0] btn_n;
  logic [3:0] hit;
  logic [3:0] unused_pressed;
  dir_t cur, q0, q1, ev, ref_dir, q0_n, q1_n;
  logic accept, pop, push, drop;
  logic [1:0] base;
  assign btn_n = {up_n, right_n, down_n, left_n};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clock(clock),
      .reset(reset),
      .btn_n(btn_n[i]),
      .pressed(unused_pressed[i]),
      .press_pulse(hit[i])
    );
  end
  assign move = MOVE_W'(cur);
  assign ev = hit[3] ? DIR_UP : hit[2] ? DIR_RIGHT : hit[1] ? DIR_DOWN : DIR_LEFT;
  // new turns are judged against the last direction the snake will have, i.e. the queue tail
  assign ref_dir = (pending == 2'd2) ? q1 : (pending == 2'd1) ? q0 : cur;
  assign accept = (|hit) && (ev != ref_dir) && !is_opposite(ev, ref_dir);
  assign pop = step && (pending != 2'd0);
  assign push = accept && (pending != 2'd2 || pop);
  assign drop = accept && (pending == 2'd2) && !step;
  // slot the new entry lands in once this cycle's pop has shifted the queue
  assign base = pending - {1'b0, pop};
  always_comb begin
    q0_n = (push && base == 2'd0) ? ev : pop ? q1 : q0;
    q1_n = (push && base == 2'd1) ? ev : q1;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur <= 3'(INIT_MOVE);
      q0 <= '0;
      q1 <= '0;
      pending <= 2'd0;
      turn_dropped <= 1'b0;
    end else begin
      if (pop) cur <= q0;
      q0 <= q0_n;
      q1 <= q1_n;
      pending <= base + {1'b0, push};
      turn_dropped <= drop;
    end
  end
endmodule
